// File: rtl/auth_pkg.sv
// Shared definitions for the login sequencer: display mode codes, FSM state
// encodings and the keyed-digit range.
package auth_pkg;

   // Mode codes consumed by the seven-segment message display.
   localparam logic [2:0] MODE_ID   = 3'b000;
   localparam logic [2:0] MODE_PSWD = 3'b001;
   localparam logic [2:0] MODE_SUCC = 3'b011;
   localparam logic [2:0] MODE_FAIL = 3'b100;

   localparam logic [3:0] DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      S_ID   = 2'd0,
      S_PSWD = 2'd1,
      S_SUCC = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   function automatic logic digit_valid(input logic [3:0] digit);
      return digit <= DIGIT_MAX;
   endfunction

endpackage

// File: rtl/auth_digit_buffer.sv
// Entry buffer: shifts in valid decimal digits, counts them and strobes
// "complete" on the DIGITS-th one, presenting the full word in that cycle.
module auth_digit_buffer
   import auth_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                load,
   input  logic [3:0]          digit,
   output logic [4*DIGITS-1:0] word,
   output logic [2:0]          count,
   output logic                complete
);

   logic [4*DIGITS-1:0] buffer;
   logic                take;

   assign take     = load && digit_valid(digit);
   // The word is the buffer with this cycle's digit appended, so the compare
   // happens on the final Enter without waiting for the shift to land.
   assign word     = (buffer << 4) | (4*DIGITS)'(digit);
   assign complete = take && (count == 3'(DIGITS - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; the buffer is reset so a partial entry never
   // survives a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buffer <= '0;
         count  <= '0;
      end else if (clear || complete) begin
         buffer <= '0;
         count  <= '0;
      end else if (take) begin
         buffer <= word;
         count  <= count + 3'd1;
      end
   end

endmodule

// File: rtl/login_auth_fsm.sv
// Login sequencer: ID entry, password entry, SUCC/FAIL. Define LOCKOUT_EN to
// make FAIL terminal until reset; otherwise FAIL times out back to ID entry.
module login_auth_fsm
   import auth_pkg::*;
#(
   parameter int                  DIGITS           = 4,
   parameter logic [4*DIGITS-1:0] ID_VALUE         = 16'h1234,
   parameter logic [4*DIGITS-1:0] PSWD_VALUE       = 16'h5678,
   parameter int                  MAX_ATTEMPTS     = 3,
   parameter int                  FAIL_HOLD_CYCLES = 50_000_000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [3:0] Digit,
   input  logic       Enter,
   input  logic       Logout,
   output logic       IdOk,
   output logic       PswdOk,
   output logic [2:0] Mode,
   output logic [2:0] DigitCount,
   output logic [2:0] AttemptsLeft
);

   state_t              state, state_nx;
   logic                id_ok_nx, pswd_ok_nx;
   logic [2:0]          mode_nx, attempts_nx;
   logic                buf_clear, buf_load, complete, fail_done;
   logic [4*DIGITS-1:0] word;

   // Logout wins over Enter, and nothing is keyed outside the entry states.
   assign buf_load  = Enter && !Logout && (state == S_ID || state == S_PSWD);
   assign buf_clear = (Logout && state != S_FAIL) || fail_done;

   auth_digit_buffer #(
      .DIGITS (DIGITS)
   ) u_buffer (
      .clk      (Clk),
      .rst_n    (Rst),
      .clear    (buf_clear),
      .load     (buf_load),
      .digit    (Digit),
      .word     (word),
      .count    (DigitCount),
      .complete (complete)
   );

`ifndef LOCKOUT_EN
   localparam int TW = (FAIL_HOLD_CYCLES > 1) ? $clog2(FAIL_HOLD_CYCLES) : 1;
   logic [TW-1:0] fail_timer, fail_timer_nx;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) fail_timer <= '0;
      else      fail_timer <= fail_timer_nx;
   end
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state        <= S_ID;
         IdOk         <= 1'b0;
         PswdOk       <= 1'b0;
         Mode         <= MODE_ID;
         AttemptsLeft <= 3'(MAX_ATTEMPTS);
      end else begin
         state        <= state_nx;
         IdOk         <= id_ok_nx;
         PswdOk       <= pswd_ok_nx;
         Mode         <= mode_nx;
         AttemptsLeft <= attempts_nx;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nx      = state;
      id_ok_nx      = IdOk;
      pswd_ok_nx    = PswdOk;
      mode_nx       = Mode;
      attempts_nx   = AttemptsLeft;
      fail_done     = 1'b0;
`ifndef LOCKOUT_EN
      fail_timer_nx = fail_timer;
`endif

      if (Logout && state != S_FAIL) begin
         state_nx    = S_ID;
         id_ok_nx    = 1'b0;
         pswd_ok_nx  = 1'b0;
         mode_nx     = MODE_ID;
         attempts_nx = 3'(MAX_ATTEMPTS);
      end else if (complete && state == S_ID) begin
         if (word == ID_VALUE) begin
            state_nx = S_PSWD;
            id_ok_nx = 1'b1;
            mode_nx  = MODE_PSWD;
         end
      end else if (complete && state == S_PSWD) begin
         if (word == PSWD_VALUE) begin
            state_nx   = S_SUCC;
            pswd_ok_nx = 1'b1;
            mode_nx    = MODE_SUCC;
         end else begin
            attempts_nx = AttemptsLeft - 3'd1;
            if (AttemptsLeft == 3'd1) begin
               state_nx = S_FAIL;
               mode_nx  = MODE_FAIL;
`ifndef LOCKOUT_EN
               fail_timer_nx = '0;
`endif
            end
         end
      end else if (state == S_FAIL) begin
`ifndef LOCKOUT_EN
         // The cycle that enters FAIL counts as the first hold cycle.
         if (fail_timer == TW'(FAIL_HOLD_CYCLES - 1)) begin
            fail_done     = 1'b1;
            fail_timer_nx = '0;
            state_nx      = S_ID;
            id_ok_nx      = 1'b0;
            pswd_ok_nx    = 1'b0;
            mode_nx       = MODE_ID;
            attempts_nx   = 3'(MAX_ATTEMPTS);
         end else begin
            fail_timer_nx = fail_timer + TW'(1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_login_auth_fsm.sv
// Directed bench for login_auth_fsm with a behavioural model feeding a
// scoreboard; honours LOCKOUT_EN the same way the design does.
module tb_login_auth_fsm;

   localparam int DIGITS = 4;
   localparam int MAXA   = 3;
   localparam int HOLD   = 8;

   logic       Clk, Rst, Enter, Logout;
   logic [3:0] Digit;
   logic       IdOk, PswdOk;
   logic [2:0] Mode, DigitCount, AttemptsLeft;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string      tag;
      logic       id_ok;
      logic       pswd_ok;
      logic [2:0] mode;
      logic [2:0] cnt;
      logic [2:0] att;
   } exp_t;

   exp_t sb[$];

   // Behavioural model; m_mode doubles as the model state.
   logic       m_id_ok, m_pswd_ok;
   logic [2:0] m_mode;
   int         m_cnt, m_buf, m_att, m_tmr;

   login_auth_fsm #(
      .DIGITS           (DIGITS),
      .ID_VALUE         (16'h1234),
      .PSWD_VALUE       (16'h5678),
      .MAX_ATTEMPTS     (MAXA),
      .FAIL_HOLD_CYCLES (HOLD)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Digit        (Digit),
      .Enter        (Enter),
      .Logout       (Logout),
      .IdOk         (IdOk),
      .PswdOk       (PswdOk),
      .Mode         (Mode),
      .DigitCount   (DigitCount),
      .AttemptsLeft (AttemptsLeft)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, compared=%0d", compared);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_id_ok = 1'b0; m_pswd_ok = 1'b0; m_mode = 3'b000;
      m_cnt = 0; m_buf = 0; m_att = MAXA; m_tmr = 0;
   endtask

   task automatic model_step(input bit en, input logic [3:0] d, input bit lo);
      if (m_mode == 3'b100) begin
`ifndef LOCKOUT_EN
         m_tmr++;
         if (m_tmr == HOLD) model_reset();
`endif
         return;
      end
      if (lo) begin
         m_mode = 3'b000; m_id_ok = 1'b0; m_pswd_ok = 1'b0;
         m_cnt = 0; m_buf = 0; m_att = MAXA;
         return;
      end
      if (en && d <= 4'd9 && (m_mode == 3'b000 || m_mode == 3'b001)) begin
         m_buf = m_buf * 16 + int'(d);
         m_cnt++;
         if (m_cnt == DIGITS) begin
            if (m_mode == 3'b000) begin
               if (m_buf == 'h1234) begin m_id_ok = 1'b1; m_mode = 3'b001; end
            end else if (m_buf == 'h5678) begin
               m_pswd_ok = 1'b1; m_mode = 3'b011;
            end else begin
               m_att--;
               if (m_att == 0) begin m_mode = 3'b100; m_tmr = 0; end
            end
            m_cnt = 0; m_buf = 0;
         end
      end
   endtask

   // Drive one cycle of stimulus, predict, then compare the registered response.
   task automatic step(input bit en, input logic [3:0] d, input bit lo, input string tag);
      exp_t e;
      Enter = en; Digit = d; Logout = lo;
      model_step(en, d, lo);
      e.tag = tag; e.id_ok = m_id_ok; e.pswd_ok = m_pswd_ok; e.mode = m_mode;
      e.cnt = 3'(m_cnt); e.att = 3'(m_att);
      sb.push_back(e);
      @(posedge Clk);
      #1;
      Enter = 1'b0; Logout = 1'b0;
      e = sb.pop_front();
      check({e.tag, ".IdOk"},         8'(IdOk),         8'(e.id_ok));
      check({e.tag, ".PswdOk"},       8'(PswdOk),       8'(e.pswd_ok));
      check({e.tag, ".Mode"},         8'(Mode),         8'(e.mode));
      check({e.tag, ".DigitCount"},   8'(DigitCount),   8'(e.cnt));
      check({e.tag, ".AttemptsLeft"}, 8'(AttemptsLeft), 8'(e.att));
   endtask

   task automatic keys(input logic [15:0] code, input string tag);
      for (int i = 3; i >= 0; i--) step(1'b1, code[4*i +: 4], 1'b0, tag);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".IdOk"},         8'(IdOk),         8'h0);
      check({tag, ".PswdOk"},       8'(PswdOk),       8'h0);
      check({tag, ".Mode"},         8'(Mode),         8'h0);
      check({tag, ".DigitCount"},   8'(DigitCount),   8'h0);
      check({tag, ".AttemptsLeft"}, 8'(AttemptsLeft), 8'(MAXA));
   endtask

   // Assert reset between edges and look before any edge can occur.
   task automatic async_reset(input string tag);
      #2 Rst = 1'b0;
      #1 check_reset_values(tag);
      model_reset();
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst = 1'b0; Enter = 1'b0; Logout = 1'b0; Digit = 4'd0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1 check_reset_values("reset");
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      #1;

      // Correct flow.
      keys(16'h1234, "id_ok");
      check("id_ok.direct_mode", 8'(Mode), 8'h1);
      check("id_ok.direct_idok", 8'(IdOk), 8'h1);
      keys(16'h5678, "pswd_ok");
      check("pswd_ok.direct_mode", 8'(Mode), 8'h3);
      check("pswd_ok.direct_pswdok", 8'(PswdOk), 8'h1);
      step(1'b1, 4'd1, 1'b0, "succ_enter_ignored");
      step(1'b0, 4'd0, 1'b1, "succ_logout");

      // Bad ID costs no attempt.
      keys(16'h1235, "bad_id");
      check("bad_id.direct_mode", 8'(Mode), 8'h0);
      check("bad_id.direct_att", 8'(AttemptsLeft), 8'd3);

      // Out-of-range digit mid-entry.
      step(1'b1, 4'd1, 1'b0, "filt_1");
      step(1'b1, 4'd2, 1'b0, "filt_2");
      step(1'b1, 4'hA, 1'b0, "filt_A");
      check("filt.direct_count", 8'(DigitCount), 8'd2);
      step(1'b1, 4'd3, 1'b0, "filt_3");
      step(1'b1, 4'd4, 1'b0, "filt_4");
      check("filt.direct_idok", 8'(IdOk), 8'h1);

      // Logout and Enter together in PSWD with two digits typed.
      step(1'b1, 4'd5, 1'b0, "lo_5");
      step(1'b1, 4'd6, 1'b0, "lo_6");
      step(1'b1, 4'd7, 1'b1, "lo_both");
      check("lo_both.direct_mode", 8'(Mode), 8'h0);
      check("lo_both.direct_count", 8'(DigitCount), 8'd0);

      // Three wrong passwords.
      keys(16'h1234, "id2");
      keys(16'h0000, "bad_pw1");
      check("bad_pw1.direct_att", 8'(AttemptsLeft), 8'd2);
      keys(16'h5679, "bad_pw2");
      check("bad_pw2.direct_att", 8'(AttemptsLeft), 8'd1);
      keys(16'h9999, "bad_pw3");
      check("bad_pw3.direct_att", 8'(AttemptsLeft), 8'd0);
      check("bad_pw3.direct_mode", 8'(Mode), 8'h4);
      check("bad_pw3.direct_idok", 8'(IdOk), 8'h1);

      // FAIL hold: Logout and Enter are ignored throughout.
      step(1'b0, 4'd0, 1'b1, "fail_logout");
      step(1'b1, 4'd1, 1'b0, "fail_enter");
      for (int i = 0; i < HOLD - 3; i++) step(1'b0, 4'd0, 1'b0, "fail_hold");
      check("fail_hold.direct_mode_last", 8'(Mode), 8'h4);
      step(1'b0, 4'd0, 1'b0, "fail_expire");
`ifdef LOCKOUT_EN
      check("lockout.direct_mode", 8'(Mode), 8'h4);
      async_reset("lockout_rst");
`else
      check("fail_expire.direct_mode", 8'(Mode), 8'h0);
      check("fail_expire.direct_att", 8'(AttemptsLeft), 8'd3);
      keys(16'h1234, "id3");
      for (int i = 0; i < MAXA; i++) keys(16'h0001, "bad_pw_again");
      step(1'b0, 4'd0, 1'b0, "fail_hold2");
      async_reset("fail_hold_rst");
`endif

      // Reset in the middle of an entry.
      step(1'b1, 4'd1, 1'b0, "mid_1");
      step(1'b1, 4'd2, 1'b0, "mid_2");
      async_reset("mid_entry_rst");
      keys(16'h1234, "post_rst_id");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
